// File: rtl/instruction_fetcher_if.sv
// Fetch-side bus bundle: dispatcher handshake plus the word-read memory port.
// The fetcher is the master; the dispatcher/memory environment is the slave.
interface instruction_fetcher_if;
    logic        dispatch_req;
    logic        ins_valid;
    logic [31:0] ins_out;
    logic [31:0] pc_out;
    logic        pred_jump_out;
    logic [31:0] pred_pc_out;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;

    modport master (
        input  dispatch_req, mem_done, mem_data,
        output ins_valid, ins_out, pc_out, pred_jump_out, pred_pc_out,
        output mem_req, mem_addr
    );

    modport slave (
        output dispatch_req, mem_done, mem_data,
        input  ins_valid, ins_out, pc_out, pred_jump_out, pred_pc_out,
        input  mem_req, mem_addr
    );
endinterface

// File: rtl/instruction_fetcher.sv
// Instruction fetcher: direct-mapped one-word I-cache, miss handling against a
// word-read memory port, and static/BHT-based next-PC prediction.
module instruction_fetcher #(
    parameter int          ICACHE_LINES = 64,
    parameter int          BHT_ENTRIES  = 256,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    instruction_fetcher_if.master        bus,
    input  logic                         mispredict,
    input  logic [31:0]                  redirect_pc,
    input  logic                         bp_update_en,
    input  logic [31:0]                  bp_update_pc,
    input  logic                         bp_update_taken
);
    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = 30 - IDX_W;
    localparam int BHT_W = $clog2(BHT_ENTRIES);

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] MEM_WAIT    = 2'd1;
    localparam logic [1:0] MEM_DISCARD = 2'd2;

    logic [1:0]              state;
    logic [31:0]             pc;
    logic [ICACHE_LINES-1:0] line_valid;
    logic [TAG_W-1:0]        line_tag  [ICACHE_LINES];
    logic [31:0]             line_data [ICACHE_LINES];
    logic [1:0]              bht       [BHT_ENTRIES];

    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic [IDX_W-1:0] fill_idx;
    logic             hit;
    logic             fill_en;
    logic [31:0]      word;
    logic [31:0]      j_imm;
    logic [31:0]      b_imm;
    logic [BHT_W-1:0] bht_rd_idx;
    logic [BHT_W-1:0] bht_wr_idx;
    logic [1:0]       bht_cur;
    logic [1:0]       bht_next;
    logic             pred_jump;
    logic [31:0]      pred_pc;
    logic             unused_bits;

    assign fetch_idx  = pc[IDX_W+1:2];
    assign fetch_tag  = pc[31:IDX_W+2];
    assign fill_idx   = bus.mem_addr[IDX_W+1:2];
    assign hit        = line_valid[fetch_idx] && (line_tag[fetch_idx] == fetch_tag);
    assign word       = line_data[fetch_idx];
    assign bht_rd_idx = pc[BHT_W+1:2];
    assign bht_wr_idx = bp_update_pc[BHT_W+1:2];
    assign bht_cur    = bht[bht_wr_idx];

    // A returning word is only accepted while a request is outstanding.
    assign fill_en = !rst && rdy && (state != IDLE) && bus.mem_done;

    assign j_imm = {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};
    assign b_imm = {{19{word[31]}}, word[31], word[7], word[30:25], word[11:8], 1'b0};

    // Address bits that never select a line, tag or counter.
    assign unused_bits = ^{pc[1:0], bus.mem_addr[1:0], bp_update_pc[31:BHT_W+2], bp_update_pc[1:0]};

    // Predecode the cached word into a taken flag and next PC.
    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        pred_jump = 1'b0;
        pred_pc   = pc + 32'd4;
        case (word[6:0])
            7'b1101111: begin
                pred_jump = 1'b1;
                pred_pc   = pc + j_imm;
            end
            7'b1100011: begin
                pred_jump = bht[bht_rd_idx][1];
                if (bht[bht_rd_idx][1]) pred_pc = pc + b_imm;
            end
            default: ;
        endcase
    end

    // Saturating 2-bit counter step for the resolved branch.
    always_comb begin
        bht_next = bht_cur;
        if (bp_update_taken && bht_cur != 2'b11)
            bht_next = bht_cur + 2'd1;
        else if (!bp_update_taken && bht_cur != 2'b00)
            bht_next = bht_cur - 2'd1;
    end

    // Line payload write on fill.
    // NOTE: data and tag arrays have no reset; the reset-cleared valid bit gates every use.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            line_data[fill_idx] <= bus.mem_data;
            line_tag[fill_idx]  <= bus.mem_addr[31:IDX_W+2];
        end
    end

    // Fetch control: FSM, PC, delivery registers, valid bits and BHT.
    // NOTE: sequential state uses non-blocking (<=) so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            pc                <= RESET_PC;
            bus.ins_valid     <= 1'b0;
            bus.ins_out       <= 32'h0;
            bus.pc_out        <= 32'h0;
            bus.pred_jump_out <= 1'b0;
            bus.pred_pc_out   <= 32'h0;
            bus.mem_req       <= 1'b0;
            bus.mem_addr      <= 32'h0;
            line_valid        <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
        end else if (!rdy) begin
            bus.ins_valid <= 1'b0;
        end else begin
            bus.ins_valid <= 1'b0;
            if (bp_update_en) bht[bht_wr_idx] <= bht_next;
            if (fill_en) begin
                line_valid[fill_idx] <= 1'b1;
                bus.mem_req          <= 1'b0;
                state                <= IDLE;
            end
            if (mispredict) begin
                pc <= redirect_pc;
                if (state == MEM_WAIT && !bus.mem_done) state <= MEM_DISCARD;
            end else if (state == IDLE && bus.dispatch_req && !bus.ins_valid) begin
                if (hit) begin
                    bus.ins_valid     <= 1'b1;
                    bus.ins_out       <= word;
                    bus.pc_out        <= pc;
                    bus.pred_jump_out <= pred_jump;
                    bus.pred_pc_out   <= pred_pc;
                    pc                <= pred_pc;
                end else begin
                    bus.mem_req  <= 1'b1;
                    bus.mem_addr <= pc;
                    state        <= MEM_WAIT;
                end
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher: a memory model answers requests after
// a fixed latency and a scoreboard holds the deliveries each step expects.
module tb_instruction_fetcher;
    localparam int MEM_LAT = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        pj;
        logic [31:0] ppc;
    } fetch_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        bp_update_en;
    logic [31:0] bp_update_pc;
    logic        bp_update_taken;

    instruction_fetcher_if bus ();

    instruction_fetcher dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .bus             (bus),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc),
        .bp_update_en    (bp_update_en),
        .bp_update_pc    (bp_update_pc),
        .bp_update_taken (bp_update_taken)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    fetch_t      sb[$];
    logic        prev_valid = 1'b0;
    int          mem_cnt = 0;
    logic        mem_hold = 1'b0;
    logic        inject_pending = 1'b0;
    logic [1:0]  bht_m [256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0:   return 32'h00000013;
            32'h8:   return 32'h0080006F;
            32'h20:  return 32'h00000463;
            32'h64:  return 32'hFFDFF06F;
            default: return (addr << 12) | 32'h13;
        endcase
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 256; i++) bht_m[i] = 2'b01;
    endtask

    task automatic expect_fetch(input logic [31:0] pc);
        fetch_t      e;
        logic [31:0] w;
        logic [31:0] imm;
        w     = mem_word(pc);
        e.pc  = pc;
        e.ins = w;
        e.pj  = 1'b0;
        e.ppc = pc + 32'd4;
        if (w[6:0] == 7'h6F) begin
            imm   = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
            e.pj  = 1'b1;
            e.ppc = pc + imm;
        end else if (w[6:0] == 7'h63) begin
            imm  = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
            e.pj = bht_m[pc[9:2]][1];
            if (e.pj) e.ppc = pc + imm;
        end
        sb.push_back(e);
    endtask

    // One clock: sample on the falling edge, score deliveries, run the memory.
    task automatic tick();
        fetch_t e;
        @(negedge clk);
        if (bus.ins_valid === 1'b1) begin
            check("no_back_to_back", 32'(prev_valid), 32'd0);
            check("delivery_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("pc_out", bus.pc_out, e.pc);
                check("ins_out", bus.ins_out, e.ins);
                check("pred_jump_out", 32'(bus.pred_jump_out), 32'(e.pj));
                check("pred_pc_out", bus.pred_pc_out, e.ppc);
            end
        end
        prev_valid = bus.ins_valid;
        if (inject_pending) begin
            bus.mem_done   = 1'b1;
            bus.mem_data   = 32'hDEADBEEF;
            inject_pending = 1'b0;
        end else if (bus.mem_done) begin
            bus.mem_done = 1'b0;
            mem_cnt      = 0;
        end else if (bus.mem_req && !mem_hold) begin
            mem_cnt++;
            if (mem_cnt >= MEM_LAT) begin
                bus.mem_done = 1'b1;
                bus.mem_data = mem_word(bus.mem_addr);
            end
        end else begin
            mem_cnt = 0;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        bus.dispatch_req = 1'b0;
        tick();
    endtask

    task automatic wait_mem_idle(input int budget);
        int n = 0;
        while (bus.mem_req && n < budget) begin
            tick();
            n++;
        end
        if (bus.mem_req) check("mem_idle_timeout", 32'(bus.mem_req), 32'd0);
    endtask

    task automatic redirect(input logic [31:0] pc);
        mispredict  = 1'b1;
        redirect_pc = pc;
        tick();
        mispredict  = 1'b0;
    endtask

    task automatic fetch_at(input logic [31:0] pc);
        redirect(pc);
        expect_fetch(pc);
        bus.dispatch_req = 1'b1;
        drain(40);
    endtask

    task automatic hit_at(input logic [31:0] pc);
        redirect(pc);
        expect_fetch(pc);
        bus.dispatch_req = 1'b1;
        tick();
        check("hit_one_cycle", 32'(bus.ins_valid), 32'd1);
        check("hit_no_mem_req", 32'(bus.mem_req), 32'd0);
        bus.dispatch_req = 1'b0;
        drain(10);
    endtask

    task automatic bp_update(input logic [31:0] pc, input logic taken);
        bp_update_en    = 1'b1;
        bp_update_pc    = pc;
        bp_update_taken = taken;
        tick();
        bp_update_en    = 1'b0;
        if (taken && bht_m[pc[9:2]] != 2'b11)
            bht_m[pc[9:2]] = bht_m[pc[9:2]] + 2'd1;
        else if (!taken && bht_m[pc[9:2]] != 2'b00)
            bht_m[pc[9:2]] = bht_m[pc[9:2]] - 2'd1;
    endtask

    initial begin
        rst              = 1'b1;
        rdy              = 1'b1;
        mispredict       = 1'b0;
        redirect_pc      = 32'h0;
        bp_update_en     = 1'b0;
        bp_update_pc     = 32'h0;
        bp_update_taken  = 1'b0;
        bus.dispatch_req = 1'b0;
        bus.mem_done     = 1'b0;
        bus.mem_data     = 32'h0;
        reset_model();

        // Reset state.
        tick();
        tick();
        check("rst_ins_valid", 32'(bus.ins_valid), 32'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_ins_out", bus.ins_out, 32'h0);
        check("rst_pc_out", bus.pc_out, 32'h0);
        check("rst_pred_jump", 32'(bus.pred_jump_out), 32'd0);
        check("rst_pred_pc", bus.pred_pc_out, 32'h0);
        rst = 1'b0;

        // Cold start: miss at 0, then delivery of the NOP.
        bus.dispatch_req = 1'b1;
        tick();
        check("cold_mem_req", 32'(bus.mem_req), 32'd1);
        check("cold_mem_addr", bus.mem_addr, 32'h0);
        check("cold_no_valid", 32'(bus.ins_valid), 32'd0);
        expect_fetch(32'h0);
        drain(30);

        // Hit path on the now-cached line 0.
        hit_at(32'h0);

        // JAL at 8 predicts 16.
        fetch_at(32'h8);

        // BEQ at 0x20: weakly not-taken, then trained taken, then back.
        fetch_at(32'h20);
        bp_update(32'h20, 1'b1);
        bp_update(32'h20, 1'b1);
        fetch_at(32'h20);
        bp_update(32'h20, 1'b0);
        bp_update(32'h20, 1'b0);
        fetch_at(32'h20);

        // Mispredict while waiting on memory: old fetch discarded but filled.
        redirect(32'h40);
        bus.dispatch_req = 1'b1;
        tick();
        check("disc_mem_req", 32'(bus.mem_req), 32'd1);
        check("disc_mem_addr", bus.mem_addr, 32'h40);
        bus.dispatch_req = 1'b0;
        mispredict       = 1'b1;
        redirect_pc      = 32'h100;
        tick();
        mispredict = 1'b0;
        check("disc_req_held", 32'(bus.mem_req), 32'd1);
        check("disc_addr_held", bus.mem_addr, 32'h40);
        wait_mem_idle(20);
        check("disc_no_valid", 32'(bus.ins_valid), 32'd0);
        bus.dispatch_req = 1'b1;
        tick();
        check("redir_mem_req", 32'(bus.mem_req), 32'd1);
        check("redir_mem_addr", bus.mem_addr, 32'h100);
        expect_fetch(32'h100);
        drain(30);
        hit_at(32'h40);

        // Two-instruction loop 0x60 -> 0x64 -> 0x60 with dispatch held.
        fetch_at(32'h60);
        expect_fetch(32'h64);
        bus.dispatch_req = 1'b1;
        drain(30);
        for (int i = 0; i < 4; i++) expect_fetch((i % 2 == 0) ? 32'h60 : 32'h64);
        bus.dispatch_req = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("loop_pattern", 32'(bus.ins_valid), 32'((i % 2) == 0));
        end
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("freeze_valid", 32'(bus.ins_valid), 32'd0);
            check("freeze_pc_out", bus.pc_out, 32'h64);
        end
        rdy = 1'b1;
        expect_fetch(32'h60);
        tick();
        check("resume_valid", 32'(bus.ins_valid), 32'd1);
        bus.dispatch_req = 1'b0;
        drain(10);

        // Reset during MEM_WAIT, then a stray mem_done that must be ignored.
        mem_hold = 1'b1;
        redirect(32'h200);
        bus.dispatch_req = 1'b1;
        tick();
        check("abandon_mem_addr", bus.mem_addr, 32'h200);
        bus.dispatch_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        reset_model();
        check("rst2_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst2_mem_addr", bus.mem_addr, 32'h0);
        check("rst2_pc_out", bus.pc_out, 32'h0);
        check("rst2_pred_pc", bus.pred_pc_out, 32'h0);
        inject_pending = 1'b1;
        tick();
        mem_hold = 1'b0;
        tick();
        check("stray_done_ignored", 32'(bus.mem_req), 32'd0);
        bus.dispatch_req = 1'b1;
        tick();
        check("post_rst_miss", 32'(bus.mem_req), 32'd1);
        check("post_rst_addr", bus.mem_addr, 32'h0);
        expect_fetch(32'h0);
        drain(30);
        redirect(32'h40);
        bus.dispatch_req = 1'b1;
        tick();
        check("valid_cleared_miss", 32'(bus.mem_req), 32'd1);
        check("valid_cleared_addr", bus.mem_addr, 32'h40);
        expect_fetch(32'h40);
        drain(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
